picomem_arb_2_1: RTL



---
 rtl/picomem_arb_2_1.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/picomem_arb_2_1.sv
// Two-master round-robin arbiter in front of a single PicoMem slave, with a
// slave-response watchdog. Slave requests and master responses are registered.
module picomem_arb_2_1 #(
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  input  logic        timeout_clr,
  output logic        timeout_err,
  output logic        busy,
  output logic        grant
);

  // Handshake: a master holds valid (and its addr/wdata/wstrb) until it sees a
  // one-cycle ready; rdata is meaningful while ready=1. Toward the slave,
  // s_valid stays high with frozen s_* until s_ready or the watchdog fires,
  // and s_ready is only honoured while s_valid=1.

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] wd_cnt;

  logic          pick;
  logic          wd_expire;
  logic          finish;
  logic [31:0]   resp_data;

  // On a tie the master that was not served most recently wins.
  always_comb begin
    pick = 1'b0;
    if (m0_valid && m1_valid) begin
      pick = ~last;
    end else if (m1_valid) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
    finish    = s_ready || wd_expire;
    resp_data = s_ready ? s_rdata : TIMEOUT_RDATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last        <= 1'b1;
      wd_cnt      <= '0;
      s_valid     <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      grant       <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      if (timeout_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant   <= pick;
            s_addr  <= pick ? m1_addr  : m0_addr;
            s_wdata <= pick ? m1_wdata : m0_wdata;
            s_wstrb <= pick ? m1_wstrb : m0_wstrb;
            s_valid <= 1'b1;
            wd_cnt  <= '0;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end

        BUSY: begin
          if (finish) begin
            s_valid <= 1'b0;
            if (grant) begin
              m1_rdata <= resp_data;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= resp_data;
              m0_ready <= 1'b1;
            end
            last <= grant;
            // A set wins over a simultaneous clear.
            if (!s_ready) begin
              timeout_err <= 1'b1;
            end
            state <= DONE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          s_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
